// File: rtl/rom_fetch_arbiter_if.sv
// rom_fetch_arbiter_if
// Toggle-handshake SDRAM port shared by the ROM fetch arbiter.
// A request is issued by flipping mem_req and completes when mem_ack matches it.
interface rom_fetch_arbiter_if;
    logic        mem_req;
    logic        mem_ack;
    logic        mem_we;
    logic [22:0] mem_a;
    logic [1:0]  mem_ds;
    logic [15:0] mem_d;
    logic [15:0] mem_q;

    modport master (
        output mem_req, mem_we, mem_a, mem_ds, mem_d,
        input  mem_ack, mem_q
    );

    modport slave (
        input  mem_req, mem_we, mem_a, mem_ds, mem_d,
        output mem_ack, mem_q
    );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter
// Shares one toggle-handshake SDRAM port between ROM download writes, two-beat
// sprite fetches and main/sound CPU ROM reads. Each read requester keeps a
// one-entry tag/data cache so SDRAM is only touched when its address moves.
// Build option ROM_ARB_AGING_EN: a starved sound CPU jumps ahead of sprite and
// main-CPU fetches after AGE_LIMIT lost grants.
module rom_fetch_arbiter #(
    parameter logic [22:0] CPU_BASE  = 23'h000000,
    parameter logic [22:0] SND_BASE  = 23'h004000,
    parameter logic [22:0] SP_BASE   = 23'h008000,
    parameter int unsigned AGE_LIMIT = 4
) (
    input  logic                       clk_sd,
    input  logic                       reset_n,
    input  logic                       dl_active_i,
    input  logic                       dl_wr_i,
    input  logic [24:0]                dl_addr_i,
    input  logic [7:0]                 dl_data_i,
    output logic                       dl_overrun_o,
    input  logic [14:0]                cpu_addr_i,
    output logic [15:0]                cpu_q_o,
    output logic                       cpu_valid_o,
    input  logic [11:0]                snd_addr_i,
    output logic [15:0]                snd_q_o,
    output logic                       snd_valid_o,
    input  logic [14:0]                sp_addr_i,
    output logic [31:0]                sp_q_o,
    output logic                       sp_valid_o,
    rom_fetch_arbiter_if.master        mem
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WAIT_SP2} state_t;
    typedef enum logic [1:0] {SRC_WR, SRC_SP, SRC_CPU, SRC_SND} src_t;

    state_t      state_q;
    src_t        src_q;
    logic        memReq_q;
    logic        memWe_q;
    logic [22:0] memA_q;
    logic [1:0]  memDs_q;
    logic [15:0] memD_q;
    logic [14:0] reqTag_q;

    logic [15:0] cpuQ_q;
    logic [15:0] sndQ_q;
    logic [31:0] spQ_q;
    logic [13:0] cpuTag_q;
    logic [11:0] sndTag_q;
    logic [14:0] spTag_q;
    logic        cpuTagValid_q;
    logic        sndTagValid_q;
    logic        spTagValid_q;

    logic        dlWrPrev_q;
    logic        pendValid_q;
    logic        overrun_q;
    logic [22:0] pendAddr_q;
    logic [1:0]  pendDs_q;
    logic [15:0] pendData_q;

    logic        cpuNeed;
    logic        sndNeed;
    logic        spNeed;
    logic        ackMatch;
    logic        dlRise;
    logic        ageBoost;
    logic        grantValid;
    logic        grantWr;
    src_t        grantSrc;
    logic [22:0] grantAddr_d;
    logic [14:0] grantTag_d;
    logic        unusedBits;

    assign cpu_valid_o = cpuTagValid_q && (cpuTag_q == cpu_addr_i[14:1]);
    assign snd_valid_o = sndTagValid_q && (sndTag_q == snd_addr_i);
    assign sp_valid_o  = spTagValid_q && (spTag_q == sp_addr_i);
    assign cpuNeed     = !cpu_valid_o;
    assign sndNeed     = !snd_valid_o;
    assign spNeed      = !sp_valid_o;

    assign cpu_q_o      = cpuQ_q;
    assign snd_q_o      = sndQ_q;
    assign sp_q_o       = spQ_q;
    assign dl_overrun_o = overrun_q;

    assign mem.mem_req = memReq_q;
    assign mem.mem_we  = memWe_q;
    assign mem.mem_a   = memA_q;
    assign mem.mem_ds  = memDs_q;
    assign mem.mem_d   = memD_q;

    assign ackMatch = (mem.mem_ack == memReq_q);
    assign dlRise   = dl_wr_i && !dlWrPrev_q;
    assign grantWr  = grantValid && (grantSrc == SRC_WR);

`ifdef ROM_ARB_AGING_EN
    logic [2:0] ageCnt_q;

    assign ageBoost   = sndNeed && (ageCnt_q >= 3'(AGE_LIMIT));
    assign unusedBits = ^{dl_addr_i[24], cpu_addr_i[0]};

    // Count grants the sound CPU loses while it is waiting; its own grant restarts the count.
    always_ff @(posedge clk_sd) begin
        if (!reset_n) begin
            ageCnt_q <= 3'd0;
        end else if (grantValid) begin
            if (grantSrc == SRC_SND) begin
                ageCnt_q <= 3'd0;
            end else if (sndNeed && (ageCnt_q != 3'd7)) begin
                ageCnt_q <= ageCnt_q + 3'd1;
            end
        end
    end
`else
    assign ageBoost   = 1'b0;
    assign unusedBits = ^{dl_addr_i[24], cpu_addr_i[0], (AGE_LIMIT != 0)};
`endif

    // Pick the next SDRAM user while idle and form the address/tag it will be issued with.
    always_comb begin
        grantValid  = 1'b0;
        grantSrc    = SRC_WR;
        grantAddr_d = pendAddr_q;
        grantTag_d  = 15'd0;
        if (state_q == S_IDLE) begin
            if (pendValid_q) begin
                grantValid = 1'b1;
                grantSrc   = SRC_WR;
            end else if (!dl_active_i) begin
                if (ageBoost) begin
                    grantValid = 1'b1;
                    grantSrc   = SRC_SND;
                end else if (spNeed) begin
                    grantValid = 1'b1;
                    grantSrc   = SRC_SP;
                end else if (cpuNeed) begin
                    grantValid = 1'b1;
                    grantSrc   = SRC_CPU;
                end else if (sndNeed) begin
                    grantValid = 1'b1;
                    grantSrc   = SRC_SND;
                end
            end
        end
        case (grantSrc)
            SRC_SP: begin
                grantAddr_d = SP_BASE + {7'd0, sp_addr_i, 1'b0};
                grantTag_d  = sp_addr_i;
            end
            SRC_CPU: begin
                grantAddr_d = CPU_BASE + {9'd0, cpu_addr_i[14:1]};
                grantTag_d  = {1'b0, cpu_addr_i[14:1]};
            end
            SRC_SND: begin
                grantAddr_d = SND_BASE + {11'd0, snd_addr_i};
                grantTag_d  = {3'd0, snd_addr_i};
            end
            default: ;
        endcase
    end

    // One-deep download write buffer; the slot frees when its write is launched, so a
    // second byte can wait behind an in-flight write and only a third one is lost.
    always_ff @(posedge clk_sd) begin
        if (!reset_n) begin
            dlWrPrev_q  <= 1'b0;
            pendValid_q <= 1'b0;
            pendAddr_q  <= 23'd0;
            pendDs_q    <= 2'b00;
            pendData_q  <= 16'h0000;
            overrun_q   <= 1'b0;
        end else begin
            dlWrPrev_q <= dl_wr_i;
            if (grantWr) begin
                pendValid_q <= 1'b0;
            end
            if (dlRise) begin
                if (pendValid_q && !grantWr) begin
                    overrun_q <= 1'b1;
                end else begin
                    pendValid_q <= 1'b1;
                    pendAddr_q  <= dl_addr_i[23:1];
                    pendDs_q    <= {dl_addr_i[0], ~dl_addr_i[0]};
                    pendData_q  <= {2{dl_data_i}};
                end
            end
        end
    end

    // Request FSM: launch the grant, hold the bus until the ack toggle matches, then fill the cache.
    always_ff @(posedge clk_sd) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            src_q         <= SRC_WR;
            memReq_q      <= 1'b0;
            memWe_q       <= 1'b0;
            memA_q        <= 23'd0;
            memDs_q       <= 2'b00;
            memD_q        <= 16'h0000;
            reqTag_q      <= 15'd0;
            cpuQ_q        <= 16'h0000;
            sndQ_q        <= 16'h0000;
            spQ_q         <= 32'h0;
            cpuTag_q      <= 14'd0;
            sndTag_q      <= 12'd0;
            spTag_q       <= 15'd0;
            cpuTagValid_q <= 1'b0;
            sndTagValid_q <= 1'b0;
            spTagValid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grantValid) begin
                        src_q    <= grantSrc;
                        reqTag_q <= grantTag_d;
                        memA_q   <= grantAddr_d;
                        memWe_q  <= grantWr;
                        memDs_q  <= grantWr ? pendDs_q : 2'b11;
                        memD_q   <= grantWr ? pendData_q : 16'h0000;
                        memReq_q <= ~memReq_q;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ackMatch) begin
                        case (src_q)
                            SRC_WR: begin
                                state_q <= S_IDLE;
                            end
                            SRC_SP: begin
                                spQ_q[15:0] <= mem.mem_q;
                                memA_q      <= memA_q + 23'd1;
                                memReq_q    <= ~memReq_q;
                                state_q     <= S_WAIT_SP2;
                            end
                            SRC_CPU: begin
                                cpuQ_q        <= mem.mem_q;
                                cpuTag_q      <= reqTag_q[13:0];
                                cpuTagValid_q <= 1'b1;
                                state_q       <= S_IDLE;
                            end
                            default: begin
                                sndQ_q        <= mem.mem_q;
                                sndTag_q      <= reqTag_q[11:0];
                                sndTagValid_q <= 1'b1;
                                state_q       <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_WAIT_SP2: begin
                    if (ackMatch) begin
                        spQ_q[31:16] <= mem.mem_q;
                        spTag_q      <= reqTag_q;
                        spTagValid_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (dl_active_i) begin
                cpuTagValid_q <= 1'b0;
                sndTagValid_q <= 1'b0;
                spTagValid_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// tb_rom_fetch_arbiter
// Directed bench for rom_fetch_arbiter: a toggle-handshake SDRAM model with
// selectable ack hold-off, a request log, a table of single-requester reads and
// hand-written sequences for reset, download/overrun, mid-cycle reset and aging.
module tb_rom_fetch_arbiter;

    localparam logic [22:0] SND_BASE = 23'h004000;

    logic        clk_sd;
    logic        reset_n;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_overrun;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_q;
    logic        cpu_valid;
    logic [11:0] snd_addr;
    logic [15:0] snd_q;
    logic        snd_valid;
    logic [14:0] sp_addr;
    logic [31:0] sp_q;
    logic        sp_valid;

    logic        ackHold;
    logic        lastReq = 1'b0;
    int          errors = 0;
    int          checks = 0;

    logic [22:0] logA[$];
    logic        logWe[$];
    logic [1:0]  logDs[$];
    logic [15:0] logD[$];
    logic [22:0] grantA[$];

    typedef struct {
        int          kind;
        logic [14:0] addr;
        logic [22:0] expA;
        logic [31:0] expQ;
        int          expLat;
    } vec_t;

    vec_t vecs[7];

    rom_fetch_arbiter_if memBus();

    rom_fetch_arbiter dut (
        .clk_sd       (clk_sd),
        .reset_n      (reset_n),
        .dl_active_i  (dl_active),
        .dl_wr_i      (dl_wr),
        .dl_addr_i    (dl_addr),
        .dl_data_i    (dl_data),
        .dl_overrun_o (dl_overrun),
        .cpu_addr_i   (cpu_addr),
        .cpu_q_o      (cpu_q),
        .cpu_valid_o  (cpu_valid),
        .snd_addr_i   (snd_addr),
        .snd_q_o      (snd_q),
        .snd_valid_o  (snd_valid),
        .sp_addr_i    (sp_addr),
        .sp_q_o       (sp_q),
        .sp_valid_o   (sp_valid),
        .mem          (memBus)
    );

    // 100 MHz SDRAM clock
    initial begin
        clk_sd = 1'b0;
        forever #5 clk_sd = ~clk_sd;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] memData(input logic [22:0] a);
        if (a == 23'h008020) return 16'h1111;
        if (a == 23'h008021) return 16'h2222;
        return a[15:0] ^ 16'hC3C3;
    endfunction

    function automatic logic isSpriteSecond(input logic [22:0] a);
        return (a >= 23'h008000) && (a < 23'h018000) && a[0];
    endfunction

    // SDRAM model: acks one cycle after a request toggle unless held off
    always @(posedge clk_sd) begin
        if (!reset_n) begin
            memBus.mem_ack <= 1'b0;
            memBus.mem_q   <= 16'h0000;
        end else if (!ackHold && (memBus.mem_req != memBus.mem_ack)) begin
            memBus.mem_ack <= memBus.mem_req;
            memBus.mem_q   <= memData(memBus.mem_a);
        end
    end

    // Request log: every mem_req toggle, plus a list of grants (sprite second beats excluded)
    always @(posedge clk_sd) begin
        #1;
        if (!reset_n) begin
            lastReq = memBus.mem_req;
        end else if (memBus.mem_req != lastReq) begin
            lastReq = memBus.mem_req;
            logA.push_back(memBus.mem_a);
            logWe.push_back(memBus.mem_we);
            logDs.push_back(memBus.mem_ds);
            logD.push_back(memBus.mem_d);
            if (memBus.mem_we || !isSpriteSecond(memBus.mem_a)) begin
                grantA.push_back(memBus.mem_a);
            end
        end
    end

    function automatic logic [41:0] logEntry(input int i);
        if (i < logA.size()) return {logWe[i], logDs[i], logD[i], logA[i]};
        return {42{1'bx}};
    endfunction

    function automatic logic validOf(input int kind);
        case (kind)
            0:       return cpu_valid;
            1:       return snd_valid;
            default: return sp_valid;
        endcase
    endfunction

    function automatic logic [31:0] qOf(input int kind);
        case (kind)
            0:       return {16'h0000, cpu_q};
            1:       return {16'h0000, snd_q};
            default: return sp_q;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int kind, input logic [14:0] addr);
        case (kind)
            0:       cpu_addr = addr;
            1:       snd_addr = addr[11:0];
            default: sp_addr  = addr;
        endcase
    endtask

    task automatic waitValid(input int kind, input int limit, output int n);
        n = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk_sd);
            if (validOf(kind)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulseDl(input logic [24:0] addr, input logic [7:0] data);
        dl_addr = addr;
        dl_data = data;
        dl_wr   = 1'b1;
        @(negedge clk_sd);
        dl_wr   = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        int sndPos;
        int expSndPos;
        logic got;

        vecs[0] = '{0, 15'h7FFF, 23'h003FFF, 32'h0000FC3C, 3};
        vecs[1] = '{0, 15'h0100, 23'h000080, 32'h0000C343, 3};
        vecs[2] = '{0, 15'h0101, 23'h000080, 32'h0000C343, 0};
        vecs[3] = '{1, 15'h0FFF, 23'h004FFF, 32'h00008C3C, 3};
        vecs[4] = '{1, 15'h0123, 23'h004123, 32'h000082E0, 3};
        vecs[5] = '{2, 15'h0010, 23'h008020, 32'h22221111, 5};
        vecs[6] = '{2, 15'h7FFF, 23'h017FFE, 32'hBC3CBC3D, 5};

        reset_n   = 1'b0;
        ackHold   = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = 25'd0;
        dl_data   = 8'h00;
        cpu_addr  = 15'h0002;
        snd_addr  = 12'h000;
        sp_addr   = 15'h0000;

        // Reset held for two clocks: everything at zero
        repeat (2) @(negedge clk_sd);
        checkOutput("reset_mem_a", memBus.mem_a, 0);
        checkOutput("reset_mem_ctl", {memBus.mem_req, memBus.mem_we, memBus.mem_ds}, 0);
        checkOutput("reset_mem_d", memBus.mem_d, 0);
        checkOutput("reset_flags", {cpu_valid, snd_valid, sp_valid, dl_overrun}, 0);
        checkOutput("reset_data", {cpu_q, snd_q, sp_q}, 0);

        // Release: all three caches are cold, served sp, cpu, snd
        reset_n = 1'b1;
        waitValid(0, 40, n);
        checkOutput("rst_cpu_latency", n, 8);
        repeat (6) @(negedge clk_sd);
        checkOutput("rst_req_count", logA.size(), 4);
        checkOutput("rst_order0", logEntry(0), {1'b0, 2'b11, 16'h0000, 23'h008000});
        checkOutput("rst_order1", logEntry(1), {1'b0, 2'b11, 16'h0000, 23'h008001});
        checkOutput("rst_order2", logEntry(2), {1'b0, 2'b11, 16'h0000, 23'h000001});
        checkOutput("rst_order3", logEntry(3), {1'b0, 2'b11, 16'h0000, 23'h004000});
        checkOutput("rst_cpu", {cpu_valid, cpu_q}, {1'b1, 16'hC3C2});
        checkOutput("rst_snd", {snd_valid, snd_q}, {1'b1, 16'h83C3});
        checkOutput("rst_sp", {sp_valid, sp_q}, {1'b1, 32'h43C243C3});
        repeat (10) @(negedge clk_sd);
        checkOutput("stable_no_toggle", logA.size(), 4);

        // Single-requester reads from the vector table
        for (int v = 0; v < 7; v++) begin
            base = logA.size();
            applyStimulus(vecs[v].kind, vecs[v].addr);
            #1;
            if (vecs[v].expLat == 0) begin
                repeat (6) @(negedge clk_sd);
                checkOutput($sformatf("vec%0d_no_fetch", v), logA.size() - base, 0);
                checkOutput($sformatf("vec%0d_valid", v), validOf(vecs[v].kind), 1);
            end else begin
                checkOutput($sformatf("vec%0d_drop", v), validOf(vecs[v].kind), 0);
                waitValid(vecs[v].kind, 30, n);
                checkOutput($sformatf("vec%0d_latency", v), n, vecs[v].expLat);
                checkOutput($sformatf("vec%0d_req", v), logEntry(base), {1'b0, 2'b11, 16'h0000, vecs[v].expA});
                if (vecs[v].kind == 2) begin
                    checkOutput($sformatf("vec%0d_req2", v), logEntry(base + 1),
                                {1'b0, 2'b11, 16'h0000, vecs[v].expA + 23'd1});
                end
                checkOutput($sformatf("vec%0d_q", v), qOf(vecs[v].kind), vecs[v].expQ);
            end
            @(negedge clk_sd);
        end

        // Download write: high byte lane, tags held invalid, no reads
        dl_active = 1'b1;
        @(negedge clk_sd);
        checkOutput("dl_tags_invalid", {cpu_valid, snd_valid, sp_valid}, 0);
        base = logA.size();
        pulseDl(25'h0010003, 8'hA5);
        repeat (6) @(negedge clk_sd);
        checkOutput("dl_count", logA.size() - base, 1);
        checkOutput("dl_write", logEntry(base), {1'b1, 2'b10, 16'hA5A5, 23'h008001});

        // Overrun: ack held off, three pulses four clocks apart
        ackHold = 1'b1;
        base = logA.size();
        pulseDl(25'h0010004, 8'h3C);
        repeat (3) @(negedge clk_sd);
        pulseDl(25'h0010006, 8'h5A);
        repeat (3) @(negedge clk_sd);
        pulseDl(25'h0010008, 8'h77);
        repeat (3) @(negedge clk_sd);
        checkOutput("ovr_issued", logA.size() - base, 1);
        checkOutput("ovr_first", logEntry(base), {1'b1, 2'b01, 16'h3C3C, 23'h008002});
        checkOutput("ovr_flag", dl_overrun, 1);
        repeat (5) @(negedge clk_sd);
        ackHold = 1'b0;
        repeat (10) @(negedge clk_sd);
        checkOutput("ovr_count", logA.size() - base, 2);
        checkOutput("ovr_second", logEntry(base + 1), {1'b1, 2'b01, 16'h5A5A, 23'h008003});
        dl_active = 1'b0;
        repeat (20) @(negedge clk_sd);
        checkOutput("ovr_sticky", dl_overrun, 1);
        checkOutput("dl_reads_resume", {cpu_valid, snd_valid, sp_valid}, 3'b111);

        // Reset in the middle of a read: cycle abandoned, overrun cleared, refetch after release
        ackHold = 1'b1;
        base = logA.size();
        cpu_addr = 15'h0400;
        repeat (3) @(negedge clk_sd);
        checkOutput("midrst_issued", logA.size() - base, 1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk_sd);
        checkOutput("midrst_req", memBus.mem_req, 0);
        checkOutput("midrst_cpu", {cpu_valid, cpu_q}, 0);
        checkOutput("midrst_overrun", dl_overrun, 0);
        ackHold = 1'b0;
        reset_n = 1'b1;
        repeat (20) @(negedge clk_sd);
        checkOutput("midrst_refetch", {cpu_valid, cpu_q}, {1'b1, 16'hC1C3});

        // Aging: sp and cpu move on every grant while snd waits
        base = grantA.size();
        snd_addr = 12'h055;
        sp_addr  = 15'h0100;
        cpu_addr = 15'h0300;
        sndPos   = 99;
        for (int g = 0; g < 6; g++) begin
            got = 1'b0;
            for (int c = 0; c < 30 && !got; c++) begin
                @(negedge clk_sd);
                if (grantA.size() > base + g) got = 1'b1;
            end
            if (!got) begin
                checkOutput("aging_grant_timeout", g, 6);
                break;
            end
            if ((grantA[base + g] == SND_BASE + 23'h055) && (sndPos == 99)) sndPos = g;
            sp_addr  = sp_addr + 15'h0001;
            cpu_addr = cpu_addr + 15'h0002;
        end
`ifdef ROM_ARB_AGING_EN
        expSndPos = 4;
`else
        expSndPos = 99;
`endif
        checkOutput("aging_first_grant", (grantA.size() > base) ? grantA[base] : 23'h7FFFFF, 23'h008200);
        checkOutput("aging_snd_grant_pos", sndPos, expSndPos);
        repeat (30) @(negedge clk_sd);
        checkOutput("aging_snd_final", {snd_valid, snd_q}, {1'b1, 16'h8396});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
